noc_vc_grant_scheduler: RTL and testbench
=========================================

Name: noc_vc_grant_scheduler

Overview:
- Packet-aware arbiter that generates the one-hot VC grant vector driving the VC mux and output FIFO stage of a router output port.
- Grants one virtual channel at a header flit and holds the grant until that VC's tail flit is accepted, so flits of different packets never interleave on the merged output.
- Round-robin across VCs by default; fixed priority is selectable.
- Re-arbitrates in the tail cycle so back-to-back packets from different VCs transfer without a bubble.

Parameters:
- CONFIG, NOC_DEFAULT_CONFIG, NoC configuration record.
- CHANNELS, CONFIG.virtual_channels (localparam), number of VCs; legal range 1..8.
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = fixed priority, lowest index wins.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- i_vc_valid  input  CHANNELS  flit valid per VC, before the mux
- i_vc_head  input  CHANNELS  per VC: current flit is a header flit
- i_vc_tail  input  CHANNELS  per VC: current flit is a tail flit; head and tail may both be 1 for a single-flit packet
- i_out_ready  input  1  merged output (FIFO input) ready
- o_vc_grant  output  CHANNELS  one-hot grant, all-zero when idle; drives the mux select
- o_busy  output  1  a packet is in progress
- o_protocol_error  output  1  sticky error flag

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - o_vc_grant=0, o_busy=0, o_protocol_error=0.
  - State=IDLE, round-robin pointer=0.
  - A reset mid-packet drops the grant the following cycle; no tail is required.
- Eligibility: VC v is eligible when i_vc_valid[v] & i_vc_head[v].
- Selection:
  - Round-robin: first eligible VC searching from the pointer upward, wrapping CHANNELS-1 to 0.
  - Fixed priority: lowest eligible index.
- Transfer: xfer = |(o_vc_grant & i_vc_valid) & i_out_ready.
- Tail transfer: last = xfer & |(o_vc_grant & i_vc_tail).
- FSM state IDLE:
  - If any VC is eligible, register the selected one-hot grant, go to BUSY, and set pointer = (sel+1) mod CHANNELS.
  - Grant is visible one cycle after the header appears; a header-to-first-transfer latency of 1 cycle is the minimum.
  - With no eligible VC, stay in IDLE with grant=0.
- FSM state BUSY:
  - Hold o_vc_grant constant.
  - On last, re-select in the same cycle among eligible VCs, excluding the VC just finished unless it is the only eligible one.
    - If one is selected, load the new grant, stay in BUSY, and update the pointer: zero-bubble back-to-back.
    - If none is selected, go to IDLE and set grant=0.
  - While i_out_ready=0 or the granted VC is invalid, hold with no timeout.
- o_busy = (state==BUSY), registered together with the grant.
- Single-flit packet (head&tail): granted, then released on its one transfer.
- Protocol error, set sticky until reset, on either of:
  - In BUSY, a transfer whose flit has head=1 that is not the first flit of the grant, i.e. a new header before the tail.
  - In IDLE, i_vc_valid[v]=1 with i_vc_head[v]=0 for 2 consecutive cycles, i.e. an orphan body flit.
  - The error flag does not alter arbitration.
- Invariants:
  - $onehot0(o_vc_grant) at all times.
  - The grant never changes in BUSY except on last.
- CHANNELS=1: grant is the 1-bit o_busy; the pointer is constant 0.
- Requests on non-granted VCs never affect the current grant.

Test Plan:
1. CHANNELS=2, reset, then VC0 drives a 3-flit packet (H,B,T) with ready=1 → grant=01 from cycle 1; 3 transfers on cycles 1-3; grant=00 at cycle 4; o_busy mirrors grant.
2. VC0 and VC1 both present headers at cycle 0, 2-flit packets, ready=1 → VC0 transfers cycles 1-2, VC1 granted at cycle 3 with no idle cycle (grant 01→10 directly); VC1 transfers cycles 3-4; pointer=0 afterwards.
3. Round-robin fairness: both VCs continuously send 1-flit packets → grant alternates 01,10,01,10 each cycle; each VC gets 50% ±1 over 100 cycles. With FIXED_PRIORITY=1 → grant stays 01 throughout.
4. Backpressure: VC1 mid-packet, i_out_ready=0 for 5 cycles while VC0 presents a header → grant held at 10 throughout; VC0 granted only after the VC1 tail transfer.
5. Reset mid-packet: rst_n=0 during flit 2 of a 4-flit VC0 packet → next cycle grant=00, busy=0, error=0; a new VC1 header after reset is granted normally.
6. Protocol errors: VC0 sends H, H without a tail → o_protocol_error=1 after the second header transfer and stays 1. Separately, after reset, VC1 holds a valid body flit for 2 idle cycles → error=1, grant stays 00.

Source files
------------

// File: rtl/noc_vc_grant_scheduler.sv
// Packet-aware VC grant scheduler for a router output port: grants one VC per
// packet (header to tail), round-robin or fixed priority, zero-bubble hand-off.

package noc_vc_grant_scheduler_pkg;

  typedef struct packed {
    logic [3:0]  virtual_channels;
    logic [15:0] flit_width;
    logic [7:0]  buffer_depth;
  } noc_config_t;

  localparam noc_config_t NOC_DEFAULT_CONFIG = '{
    virtual_channels: 4'd2,
    flit_width:       16'd64,
    buffer_depth:     8'd4
  };

endpackage

module noc_vc_grant_scheduler
  import noc_vc_grant_scheduler_pkg::*;
#(
  parameter noc_config_t CONFIG = NOC_DEFAULT_CONFIG,
  parameter int unsigned FIXED_PRIORITY = 0,
  localparam int unsigned CHANNELS = 32'(CONFIG.virtual_channels)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] i_vc_valid,
  input  logic [CHANNELS-1:0] i_vc_head,
  input  logic [CHANNELS-1:0] i_vc_tail,
  input  logic                i_out_ready,
  output logic [CHANNELS-1:0] o_vc_grant,
  output logic                o_busy,
  output logic                o_protocol_error
);

  localparam int unsigned PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                first_q, first_d;
  logic                err_q, err_d;
  logic [CHANNELS-1:0] orphan_q, orphan_d;

  logic [CHANNELS-1:0] eligible;
  logic                xfer;
  logic                last;
  logic                xfer_head;
  logic                sel_any;
  logic [CHANNELS-1:0] sel_oh;
  logic [PTR_W-1:0]    sel_next;

  assign eligible  = i_vc_valid & i_vc_head;
  assign xfer      = (|(grant_q & i_vc_valid)) & i_out_ready;
  assign last      = xfer & (|(grant_q & i_vc_tail));
  assign xfer_head = xfer & (|(grant_q & i_vc_head));

  // Winner search; round-robin starts at the pointer, which already sits just
  // past the VC being finished, so that VC only wins when it is alone.
  always_comb begin : select
    logic [CHANNELS-1:0] excl;
    logic [CHANNELS-1:0] req;
    int unsigned         idx;
    excl     = eligible & ~grant_q;
    req      = eligible;
    idx      = 0;
    sel_any  = 1'b0;
    sel_oh   = '0;
    sel_next = '0;
    if (FIXED_PRIORITY == 0 && state_q == ST_BUSY && excl != '0) begin
      req = excl;
    end
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = i + ((FIXED_PRIORITY != 0) ? 32'd0 : 32'(ptr_q));
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end
      if (!sel_any && req[PTR_W'(idx)]) begin
        sel_any              = 1'b1;
        sel_oh[PTR_W'(idx)]  = 1'b1;
        sel_next             = (idx == CHANNELS - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin : fsm_next
    state_d  = state_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    ptr_d    = ptr_q;
    first_d  = first_q;
    err_d    = err_q;
    orphan_d = '0;
    case (state_q)
      ST_IDLE: begin
        orphan_d = i_vc_valid & ~i_vc_head;
        if ((orphan_d & orphan_q) != '0) begin
          err_d = 1'b1;
        end
        if (sel_any) begin
          state_d = ST_BUSY;
          grant_d = sel_oh;
          busy_d  = 1'b1;
          ptr_d   = sel_next;
          first_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (xfer) begin
          first_d = 1'b0;
          if (xfer_head && !first_q) begin
            err_d = 1'b1;
          end
        end
        if (last) begin
          if (sel_any) begin
            grant_d = sel_oh;
            ptr_d   = sel_next;
            first_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            first_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin : regs
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      ptr_q    <= '0;
      first_q  <= 1'b0;
      err_q    <= 1'b0;
      orphan_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      ptr_q    <= ptr_d;
      first_q  <= first_d;
      err_q    <= err_d;
      orphan_q <= orphan_d;
    end
  end

  assign o_vc_grant       = grant_q;
  assign o_busy           = busy_q;
  assign o_protocol_error = err_q;

endmodule

// File: tb/tb_noc_vc_grant_scheduler.sv
// Directed bench for noc_vc_grant_scheduler with two VCs; a second instance
// runs fixed priority on the same stimulus.

module tb_noc_vc_grant_scheduler;

  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic [1:0] v;
    logic [1:0] h;
    logic [1:0] t;
    logic [1:0] g;
    logic       e;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] i_vc_valid;
  logic [1:0] i_vc_head;
  logic [1:0] i_vc_tail;
  logic       i_out_ready;
  logic [1:0] o_vc_grant;
  logic       o_busy;
  logic       o_protocol_error;
  logic [1:0] grant_fp;
  logic       busy_fp;
  logic       err_fp;

  int vectors;
  int miscompares;

  noc_vc_grant_scheduler #(.FIXED_PRIORITY(0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_vc_valid      (i_vc_valid),
    .i_vc_head       (i_vc_head),
    .i_vc_tail       (i_vc_tail),
    .i_out_ready     (i_out_ready),
    .o_vc_grant      (o_vc_grant),
    .o_busy          (o_busy),
    .o_protocol_error(o_protocol_error)
  );

  noc_vc_grant_scheduler #(.FIXED_PRIORITY(1)) dut_fp (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_vc_valid      (i_vc_valid),
    .i_vc_head       (i_vc_head),
    .i_vc_tail       (i_vc_tail),
    .i_out_ready     (i_out_ready),
    .o_vc_grant      (grant_fp),
    .o_busy          (busy_fp),
    .o_protocol_error(err_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    i_vc_valid  = 2'b00;
    i_vc_head   = 2'b00;
    i_vc_tail   = 2'b00;
    i_out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    i_vc_valid  = 2'b11;
    i_vc_head   = 2'b11;
    i_vc_tail   = 2'b00;
    i_out_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if (o_vc_grant !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_grant got %b want 00", o_vc_grant);
    end
    vectors++;
    if (o_busy !== 1'b0 || o_protocol_error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags got busy=%b err=%b want 0 0", o_busy, o_protocol_error);
    end
    vectors++;
    if (grant_fp !== 2'b00 || busy_fp !== 1'b0 || err_fp !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_fp got g=%b busy=%b err=%b want 00 0 0", grant_fp, busy_fp, err_fp);
    end
    rst_n = 1'b1;
  endtask

  // Fields per row: rst rdy valid head tail | expected grant err (busy = |grant).
  task automatic test_single_packet();
    logic [10:0] tbl [5];
    vec_t cur;
    tbl = '{11'b1_1_01_01_00_00_0,
            11'b1_1_01_01_00_01_0,
            11'b1_1_01_00_00_01_0,
            11'b1_1_01_00_01_01_0,
            11'b1_1_00_00_00_00_0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cur = vec_t'(tbl[k]);
      rst_n = cur.rst; i_out_ready = cur.rdy;
      i_vc_valid = cur.v; i_vc_head = cur.h; i_vc_tail = cur.t;
      vectors++;
      if (o_vc_grant !== cur.g) begin
        miscompares++;
        $display("FAIL single k=%0d grant got %b want %b", k, o_vc_grant, cur.g);
      end
      vectors++;
      if (o_busy !== (cur.g != 2'b00)) begin
        miscompares++;
        $display("FAIL single k=%0d busy got %b want %b", k, o_busy, cur.g != 2'b00);
      end
      vectors++;
      if (o_protocol_error !== cur.e) begin
        miscompares++;
        $display("FAIL single k=%0d err got %b want %b", k, o_protocol_error, cur.e);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] tbl [7];
    vec_t cur;
    tbl = '{11'b1_1_11_11_00_00_0,
            11'b1_1_11_11_00_01_0,
            11'b1_1_11_10_01_01_0,
            11'b1_1_10_10_00_10_0,
            11'b1_1_10_00_10_10_0,
            11'b1_1_11_11_00_00_0,
            11'b1_1_11_11_00_01_0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      cur = vec_t'(tbl[k]);
      rst_n = cur.rst; i_out_ready = cur.rdy;
      i_vc_valid = cur.v; i_vc_head = cur.h; i_vc_tail = cur.t;
      vectors++;
      if (o_vc_grant !== cur.g) begin
        miscompares++;
        $display("FAIL b2b k=%0d grant got %b want %b", k, o_vc_grant, cur.g);
      end
      vectors++;
      if (o_busy !== (cur.g != 2'b00)) begin
        miscompares++;
        $display("FAIL b2b k=%0d busy got %b want %b", k, o_busy, cur.g != 2'b00);
      end
      vectors++;
      if (o_protocol_error !== cur.e) begin
        miscompares++;
        $display("FAIL b2b k=%0d err got %b want %b", k, o_protocol_error, cur.e);
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    int cnt0;
    int cnt1;
    logic [1:0] want;
    cnt0 = 0;
    cnt1 = 0;
    do_reset();
    i_vc_valid = 2'b11; i_vc_head = 2'b11; i_vc_tail = 2'b11; i_out_ready = 1'b1;
    tick();
    for (int k = 1; k <= 100; k++) begin
      want = (k % 2 == 1) ? 2'b01 : 2'b10;
      vectors++;
      if (o_vc_grant !== want) begin
        miscompares++;
        $display("FAIL rr k=%0d grant got %b want %b", k, o_vc_grant, want);
      end
      vectors++;
      if (grant_fp !== 2'b01) begin
        miscompares++;
        $display("FAIL fixed k=%0d grant got %b want 01", k, grant_fp);
      end
      if (o_vc_grant == 2'b01) cnt0++;
      if (o_vc_grant == 2'b10) cnt1++;
      tick();
    end
    vectors++;
    if (cnt0 < 49 || cnt0 > 51 || cnt1 < 49 || cnt1 > 51) begin
      miscompares++;
      $display("FAIL rr_share got vc0=%0d vc1=%0d want 50 each +-1", cnt0, cnt1);
    end
    vectors++;
    if (o_protocol_error !== 1'b0 || err_fp !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_err got %b/%b want 0/0", o_protocol_error, err_fp);
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] tbl [12];
    vec_t cur;
    tbl = '{11'b1_1_10_10_00_00_0,
            11'b1_1_10_10_00_10_0,
            11'b1_0_11_01_00_10_0,
            11'b1_0_11_01_00_10_0,
            11'b1_0_11_01_00_10_0,
            11'b1_0_11_01_00_10_0,
            11'b1_0_11_01_00_10_0,
            11'b1_1_11_01_00_10_0,
            11'b1_1_11_01_10_10_0,
            11'b1_1_01_01_00_01_0,
            11'b1_1_01_00_01_01_0,
            11'b1_1_00_00_00_00_0};
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cur = vec_t'(tbl[k]);
      rst_n = cur.rst; i_out_ready = cur.rdy;
      i_vc_valid = cur.v; i_vc_head = cur.h; i_vc_tail = cur.t;
      vectors++;
      if (o_vc_grant !== cur.g) begin
        miscompares++;
        $display("FAIL bp k=%0d grant got %b want %b", k, o_vc_grant, cur.g);
      end
      vectors++;
      if (o_busy !== (cur.g != 2'b00)) begin
        miscompares++;
        $display("FAIL bp k=%0d busy got %b want %b", k, o_busy, cur.g != 2'b00);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [10:0] tbl [7];
    vec_t cur;
    tbl = '{11'b1_1_01_01_00_00_0,
            11'b1_1_01_01_00_01_0,
            11'b0_1_01_00_00_01_0,
            11'b1_1_10_10_00_00_0,
            11'b1_1_10_10_00_10_0,
            11'b1_1_10_00_10_10_0,
            11'b1_1_00_00_00_00_0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      cur = vec_t'(tbl[k]);
      rst_n = cur.rst; i_out_ready = cur.rdy;
      i_vc_valid = cur.v; i_vc_head = cur.h; i_vc_tail = cur.t;
      vectors++;
      if (o_vc_grant !== cur.g) begin
        miscompares++;
        $display("FAIL rstmid k=%0d grant got %b want %b", k, o_vc_grant, cur.g);
      end
      vectors++;
      if (o_busy !== (cur.g != 2'b00)) begin
        miscompares++;
        $display("FAIL rstmid k=%0d busy got %b want %b", k, o_busy, cur.g != 2'b00);
      end
      vectors++;
      if (o_protocol_error !== cur.e) begin
        miscompares++;
        $display("FAIL rstmid k=%0d err got %b want %b", k, o_protocol_error, cur.e);
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_protocol_error();
    logic [10:0] tbl [10];
    vec_t cur;
    tbl = '{11'b1_1_01_01_00_00_0,
            11'b1_1_01_01_00_01_0,
            11'b1_1_01_01_00_01_0,
            11'b1_1_00_00_00_01_1,
            11'b1_1_01_00_01_01_1,
            11'b1_1_00_00_00_00_1,
            11'b0_1_00_00_00_00_1,
            11'b1_1_10_00_00_00_0,
            11'b1_1_10_00_00_00_0,
            11'b1_1_00_00_00_00_1};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cur = vec_t'(tbl[k]);
      rst_n = cur.rst; i_out_ready = cur.rdy;
      i_vc_valid = cur.v; i_vc_head = cur.h; i_vc_tail = cur.t;
      vectors++;
      if (o_vc_grant !== cur.g) begin
        miscompares++;
        $display("FAIL proto k=%0d grant got %b want %b", k, o_vc_grant, cur.g);
      end
      vectors++;
      if (o_protocol_error !== cur.e) begin
        miscompares++;
        $display("FAIL proto k=%0d err got %b want %b", k, o_protocol_error, cur.e);
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    i_vc_valid  = 2'b00;
    i_vc_head   = 2'b00;
    i_vc_tail   = 2'b00;
    i_out_ready = 1'b0;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_fairness();
    test_backpressure();
    test_reset_mid_packet();
    test_protocol_error();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
